// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the pipeline and the mul/div engine
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI_out;
    logic [WIDTH-1:0] LO_out;
    logic             HI_Ld;
    logic             LO_Ld;
    logic             DivZero;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, HI_out, LO_out, HI_Ld, LO_Ld, DivZero
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, HI_out, LO_out, HI_Ld, LO_Ld, DivZero
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle shift-add multiplier / restoring divider feeding HI/LO
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           Clk,
    input logic           Clr,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_hi;
    logic             neg_lo;
    logic [WIDTH-1:0] opnd;     // multiplicand (mul) or divisor (div), magnitude
    logic [WIDTH-1:0] hi_w;     // accumulator (mul) or partial remainder (div)
    logic [WIDTH-1:0] lo_w;     // multiplier (mul) or dividend/quotient (div)
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             div_zero_q;

    // Decode of the incoming request
    logic             op_div;
    logic             op_signed;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign op_div    = bus.Op[1];
    assign op_signed = ~bus.Op[0];
    assign b_zero    = (bus.B == '0);
    // Two's-complement negation maps 0x80..0 onto itself, which is the magnitude we want
    assign abs_a     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // One iteration of each algorithm, evaluated every cycle
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    // The 33-bit sum keeps the carry so it can shift down into the accumulator MSB
    assign mul_sum  = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opnd} : '0);
    // The shifted remainder needs WIDTH+1 bits when the divisor has its MSB set
    assign div_sh   = {hi_w, lo_w[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign prod     = {hi_w, lo_w};
    assign prod_neg = -prod;

    // State register
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_next = (op_div && b_zero) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = FIXUP;
                end
            end
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge Clk) begin
        if (Clr) begin
            cnt        <= '0;
            is_div     <= 1'b0;
            neg_hi     <= 1'b0;
            neg_lo     <= 1'b0;
            opnd       <= '0;
            hi_w       <= '0;
            lo_w       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        cnt        <= '0;
                        is_div     <= op_div;
                        neg_lo     <= op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_hi     <= op_signed & (op_div ? bus.A[WIDTH-1]
                                                          : (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]));
                        hi_w       <= '0;
                        div_zero_q <= op_div & b_zero;
                        if (op_div) begin
                            opnd <= abs_b;
                            lo_w <= abs_a;
                        end else begin
                            opnd <= abs_a;
                            lo_w <= abs_b;
                        end
                        // Divide by zero skips the iterations and reports immediately
                        if (op_div && b_zero) begin
                            hi_q <= bus.A;
                            lo_q <= '1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            hi_w <= div_diff[WIDTH-1:0];
                            lo_w <= {lo_w[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_w <= div_sh[WIDTH-1:0];
                            lo_w <= {lo_w[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_w <= mul_sum[WIDTH:1];
                        lo_w <= {mul_sum[0], lo_w[WIDTH-1:1]};
                    end
                end
                FIXUP: begin
                    if (is_div) begin
                        lo_q <= neg_lo ? -lo_w : lo_w;
                        hi_q <= neg_hi ? -hi_w : hi_w;
                    end else if (neg_hi) begin
                        hi_q <= prod_neg[2*WIDTH-1:WIDTH];
                        lo_q <= prod_neg[WIDTH-1:0];
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy    = (state == RUN) || (state == FIXUP);
    assign bus.Done    = (state == DONE);
    assign bus.HI_Ld   = (state == DONE);
    assign bus.LO_Ld   = (state == DONE);
    assign bus.HI_out  = hi_q;
    assign bus.LO_out  = lo_q;
    assign bus.DivZero = div_zero_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic Clk = 1'b0;
    logic Clr = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse is matched against the oldest expected result
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (bus.Done) begin
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("hi_out", {32'd0, bus.HI_out}, {32'd0, e.hi});
                chk("lo_out", {32'd0, bus.LO_out}, {32'd0, e.lo});
                chk("divzero", {63'd0, bus.DivZero}, {63'd0, e.dz});
                chk("hi_ld", {63'd0, bus.HI_Ld}, 64'd1);
                chk("lo_ld", {63'd0, bus.LO_Ld}, 64'd1);
                chk("latency", 64'(cyc - e.issue), 64'(e.lat));
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        exp_t e;
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        e.hi    = hi;
        e.lo    = lo;
        e.dz    = dz;
        e.lat   = dz ? 1 : 34;
        e.issue = cyc;
        sb.push_back(e);
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic finish_op(input logic dz, input int exp_busy);
        int busy_cnt;
        busy_cnt = 0;
        #1;
        chk("divzero_at_accept", {63'd0, bus.DivZero}, {63'd0, dz});
        for (int n = 0; n < 80; n++) begin
            if (sb.size() == 0) break;
            if (bus.Busy) busy_cnt++;
            @(negedge Clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'd1, 64'd0);
            sb.delete();
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        chk("busy_low_at_done", {63'd0, bus.Busy}, 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        start_op(op, a, b, hi, lo, dz);
        finish_op(dz, dz ? 0 : 33);
    endtask

    initial begin
        int dc;
        bus.Start = 1'b0;
        bus.Op    = MULTU;
        bus.A     = 32'hFFFF_FFFF;
        bus.B     = 32'hFFFF_FFFF;
        // Reset with a Start pending: reset must win
        bus.Start = 1'b1;
        repeat (3) @(negedge Clk);
        bus.Start = 1'b0;
        #1;
        chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
        chk("rst_done", {63'd0, bus.Done}, 64'd0);
        chk("rst_ld", {62'd0, bus.HI_Ld, bus.LO_Ld}, 64'd0);
        chk("rst_divzero", {63'd0, bus.DivZero}, 64'd0);
        chk("rst_hilo", {bus.HI_out, bus.LO_out}, 64'd0);
        Clr = 1'b0;

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op(MULT,  32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0);
        run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        run_op(DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1,         1'b0);
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        run_op(DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op(MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0);
        run_op(DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

        // A second Start while running must be ignored
        start_op(MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        repeat (4) @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 32'd7;
        bus.B     = 32'd9;
        @(negedge Clk);
        bus.Start = 1'b0;
        finish_op(1'b0, 28);
        chk("divzero_cleared", {63'd0, bus.DivZero}, 64'd0);

        // Clr aborts an operation in flight: no Done, outputs cleared
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = MULTU;
        bus.A     = 32'd5;
        bus.B     = 32'd5;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
        chk("abort_hilo", {bus.HI_out, bus.LO_out}, 64'd0);
        chk("abort_divzero", {63'd0, bus.DivZero}, 64'd0);
        dc = done_count;
        repeat (40) @(negedge Clk);
        #1;
        chk("abort_no_done", 64'(done_count), 64'(dc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
